// File: rtl/apb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : apb_decoder
// Description : Single-initiator, four-target APB splitter. An upstream APB
//               transfer is decoded against four base/mask regions, re-issued
//               as a registered transfer on the selected downstream port, and
//               the registered response is returned upstream. Unmapped
//               addresses and targets that exceed TIMEOUT access cycles
//               complete upstream with PSLVERR.
// Ports       : pclk, preset_n (async, active-low)
//               s_*  upstream APB target port (s_pready/s_pslverr/s_prdata
//                    are registered)
//               m_*  downstream APB initiator port; m_psel is one-hot per
//                    target, the rest is shared; m_prdata packs target i at
//                    [i*DW +: DW]
// Revision    : 1.0 - initial release
// ============================================================================
module apb_decoder #(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int          PROT_W  = 3,
    parameter int          PSTRB_W = 4,
    parameter logic [AW-1:0] S0_BASE = AW'(32'h0000_0000),
    parameter logic [AW-1:0] S1_BASE = AW'(32'h0000_1000),
    parameter logic [AW-1:0] S2_BASE = AW'(32'h0000_2000),
    parameter logic [AW-1:0] S3_BASE = AW'(32'h0000_3000),
    parameter logic [AW-1:0] S0_MASK = AW'(32'hFFFF_F000),
    parameter logic [AW-1:0] S1_MASK = AW'(32'hFFFF_F000),
    parameter logic [AW-1:0] S2_MASK = AW'(32'hFFFF_F000),
    parameter logic [AW-1:0] S3_MASK = AW'(32'hFFFF_F000),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                s_psel,
    input  logic                s_penable,
    input  logic                s_pwrite,
    input  logic [AW-1:0]       s_paddr,
    input  logic [DW-1:0]       s_pwdata,
    input  logic [PSTRB_W-1:0]  s_pstrb,
    input  logic [PROT_W-1:0]   s_pprot,
    output logic                s_pready,
    output logic                s_pslverr,
    output logic [DW-1:0]       s_prdata,
    output logic [3:0]          m_psel,
    output logic                m_penable,
    output logic                m_pwrite,
    output logic [AW-1:0]       m_paddr,
    output logic [DW-1:0]       m_pwdata,
    output logic [PSTRB_W-1:0]  m_pstrb,
    output logic [PROT_W-1:0]   m_pprot,
    input  logic [3:0]          m_pready,
    input  logic [3:0]          m_pslverr,
    input  logic [4*DW-1:0]     m_prdata
);

    localparam logic [AW-1:0] c_BASE [4] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
    localparam logic [AW-1:0] c_MASK [4] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};
    localparam bit            c_TO_EN    = (TIMEOUT != 0);
    localparam int unsigned   c_TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [1:0]          r_tgt,     w_tgt_nxt;
    logic [15:0]         r_cnt,     w_cnt_nxt;
    logic [3:0]          r_sel,     w_sel_nxt;
    logic                r_penable, w_penable_nxt;
    logic                r_pwrite,  w_pwrite_nxt;
    logic [AW-1:0]       r_paddr,   w_paddr_nxt;
    logic [DW-1:0]       r_pwdata,  w_pwdata_nxt;
    logic [PSTRB_W-1:0]  r_pstrb,   w_pstrb_nxt;
    logic [PROT_W-1:0]   r_pprot,   w_pprot_nxt;
    logic                r_pready,  w_pready_nxt;
    logic                r_pslverr, w_pslverr_nxt;
    logic [DW-1:0]       r_prdata,  w_prdata_nxt;

    logic [3:0]          w_hit;
    logic                w_any_hit;
    logic [1:0]          w_hit_idx;
    logic [DW-1:0]       w_rdata [4];

    // Region compare and read-data unpacking per target
    for (genvar i = 0; i < 4; i++) begin : g_tgt
        assign w_hit[i]   = ((s_paddr & c_MASK[i]) == c_BASE[i]);
        assign w_rdata[i] = m_prdata[i*DW +: DW];
    end

    // Overlapping regions resolve to the lowest index
    always_comb begin
        w_any_hit = |w_hit;
        w_hit_idx = 2'd0;
        if (w_hit[0])      w_hit_idx = 2'd0;
        else if (w_hit[1]) w_hit_idx = 2'd1;
        else if (w_hit[2]) w_hit_idx = 2'd2;
        else if (w_hit[3]) w_hit_idx = 2'd3;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state   <= ST_IDLE;
            r_tgt     <= '0;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pprot   <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tgt     <= w_tgt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_pstrb   <= w_pstrb_nxt;
            r_pprot   <= w_pprot_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tgt_nxt     = r_tgt;
        w_cnt_nxt     = r_cnt;
        w_sel_nxt     = r_sel;
        w_penable_nxt = r_penable;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_pstrb_nxt   = r_pstrb;
        w_pprot_nxt   = r_pprot;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;
        // The response pulse is registered: it is raised on entry to RESP
        // so that s_pready is high exactly during the RESP cycle.
        w_pready_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_psel && !s_penable) begin
                    w_pwrite_nxt = s_pwrite;
                    w_paddr_nxt  = s_paddr;
                    w_pwdata_nxt = s_pwdata;
                    w_pstrb_nxt  = s_pstrb;
                    w_pprot_nxt  = s_pprot;
                    if (w_any_hit) begin
                        w_state_nxt   = ST_SETUP;
                        w_tgt_nxt     = w_hit_idx;
                        w_sel_nxt     = 4'b0001 << w_hit_idx;
                        w_penable_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = ST_RESP;
                        w_pslverr_nxt = 1'b1;
                        w_prdata_nxt  = '0;
                        w_pready_nxt  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m_pready[r_tgt]) begin
                    w_sel_nxt     = '0;
                    w_penable_nxt = 1'b0;
                    w_pslverr_nxt = m_pslverr[r_tgt];
                    w_prdata_nxt  = r_pwrite ? '0 : w_rdata[r_tgt];
                    w_pready_nxt  = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else if (c_TO_EN && (r_cnt == c_TO_LAST[15:0])) begin
                    // Counter value TIMEOUT-1 marks the TIMEOUT-th ACCESS cycle
                    w_sel_nxt     = '0;
                    w_penable_nxt = 1'b0;
                    w_pslverr_nxt = 1'b1;
                    w_prdata_nxt  = '0;
                    w_pready_nxt  = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_pready  = r_pready;
    assign s_pslverr = r_pslverr;
    assign s_prdata  = r_prdata;
    assign m_psel    = r_sel;
    assign m_penable = r_penable;
    assign m_pwrite  = r_pwrite;
    assign m_paddr   = r_paddr;
    assign m_pwdata  = r_pwdata;
    assign m_pstrb   = r_pstrb;
    assign m_pprot   = r_pprot;

endmodule
`default_nettype wire

// File: doc/apb_decoder.md
Name: apb_decoder

Overview:
- Single-initiator to four-target APB splitter, the fan-out counterpart of the team's 4:1 APB arbiter.
- Accepts one APB transfer on its upstream target port and decodes PADDR against four parameterised regions.
- Re-issues the transfer as a registered APB transfer on the selected downstream port and returns the registered response upstream.
- Unmapped addresses and hung targets (timeout) complete upstream with PSLVERR.

Parameters:
AW, 32, address width
DW, 32, data width
PROT_W, 3, PPROT width
PSTRB_W, 4, PSTRB width
S0_BASE..S3_BASE, 32'h0000_0000 / 32'h0000_1000 / 32'h0000_2000 / 32'h0000_3000, region base per target
S0_MASK..S3_MASK, 32'hFFFF_F000 (all four), region compare mask per target
TIMEOUT, 255, maximum downstream ACCESS cycles before abort; 0 disables timeout; legal range 0..65535

Ports:
pclk  in  1  clock
preset_n  in  1  asynchronous active-low reset
s_psel, s_penable, s_pwrite  in  1 each  upstream APB control
s_paddr  in  AW  upstream address
s_pwdata  in  DW  upstream write data
s_pstrb  in  PSTRB_W  upstream write strobes
s_pprot  in  PROT_W  upstream protection
s_pready  out  1  upstream ready, registered
s_pslverr  out  1  upstream error, registered
s_prdata  out  DW  upstream read data, registered
m_psel  out  4  one-hot downstream select, bit i = target i
m_penable, m_pwrite  out  1 each  shared downstream control
m_paddr, m_pwdata, m_pstrb, m_pprot  out  AW/DW/PSTRB_W/PROT_W  shared downstream payload
m_pready, m_pslverr  in  4 each  per-target response
m_prdata  in  4*DW  per-target read data, target i at [i*DW +: DW]

Behaviour:
- Reset (preset_n=0, asynchronous): state=IDLE; all outputs 0, including s_pready, m_psel and the payload; timeout counter 0.
- Decode: hit_i = ((s_paddr & Si_MASK) == Si_BASE). If regions overlap, the lowest index wins. No hit means miss.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On s_psel=1 && s_penable=0, capture pwrite/paddr/pwdata/pstrb/pprot into m_* registers.
  - On a hit to target i: next state SETUP, m_psel[i]<=1, m_penable<=0.
  - On a miss: next state RESP, with s_pslverr=1 and s_prdata=0 loaded for the RESP cycle.
  - All other inputs are ignored in IDLE.
- SETUP: m_penable<=1; counter cleared; next state ACCESS.
- ACCESS (target i):
  - On m_pready[i]=1: m_psel<=0, m_penable<=0, s_pslverr<=m_pslverr[i], s_prdata<=(m_pwrite ? 0 : m_prdata[i]); next state RESP.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no pready, abort: m_psel<=0, m_penable<=0, s_pslverr<=1, s_prdata<=0; next state RESP.
- RESP: s_pready=1 for exactly one cycle; next state IDLE; s_pready returns to 0.
- s_pslverr and s_prdata hold their values until the next RESP load.
- s_pready is 0 in every state except RESP. The upstream initiator therefore waits in its access phase.
- Latency, zero-wait target, setup sampled at edge T:
  - m_psel high after T.
  - m_penable high after T+1.
  - m_pready sampled at T+2.
  - s_pready high in the cycle after T+2 and sampled by the initiator at T+3.
  - Each downstream wait state adds 1 cycle.
- Miss latency: s_pready high in the cycle after T.
- Upstream control changes mid-transfer (s_psel dropped): the downstream transfer still completes or times out normally. The upstream response pulse is still issued.
- A new upstream setup is accepted only in IDLE. Back-to-back transfers with no idle cycle between them are supported.
- m_paddr, m_pwdata and the other payload registers hold their values after a transfer until the next capture.
- m_pready and m_pslverr of unselected targets are ignored.
- Reset asserted mid-transfer: every output goes to 0 immediately. No response is owed.

Test Plan:
- Read 0x1004, target 1 zero-wait returning prdata=0xCAFE_F00D: m_psel=4'b0010 for 2 cycles, penable on the 2nd; s_pready pulses at T+3 with s_prdata=0xCAFE_F00D, s_pslverr=0.
- Write 0x3010 data 0x1234_5678 strb 4'b0011, target 3 inserts 3 wait states: m_pwdata/m_pstrb match; s_pready sampled at T+6; s_prdata=0; m_pslverr[3]=1 appears as s_pslverr=1.
- Access 0x8000 (unmapped): no m_psel bit set; s_pready pulses the cycle after T with s_pslverr=1, s_prdata=0.
- TIMEOUT=4, target 2 never readies: m_penable high for exactly 4 cycles, then m_psel=0; s_pready with s_pslverr=1; a following transfer to target 0 completes normally.
- S0_MASK=32'hFFFF_0000 overlapping target 1, access 0x1000: m_psel=4'b0001.
- Assert preset_n low during ACCESS: all outputs 0 asynchronously; after release, a read to target 0 completes with the nominal latency.
